// File: rtl/css_pkg.sv
// Shared types for the CSS row feeder: FSM state encoding and drain length.
package css_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } feeder_state_t;

  // Cycles after the last pixel before the final window reaches win_valid.
  localparam int DRAIN_CYCLES = 3;

endpackage

// File: rtl/line_buffer_ram.sv
// One-row line buffer: 1R1W synchronous RAM, registered read data held between reads.
module line_buffer_ram #(
  parameter int DEPTH = 1024,
  parameter int DW    = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/css_row_feeder.sv
// Raster pixel stream to CSS 3x3 window column feeder with two line buffers.
// State | meaning: IDLE wait for start | STREAM accept pixels | DRAIN flush last window.
module css_row_feeder
  import css_pkg::*;
#(
  parameter int IO_DATA_WIDTH      = 16,
  parameter int FEATURE_MAP_WIDTH  = 1024,
  parameter int FEATURE_MAP_HEIGHT = 1024
) (
  input  logic                                  clk,
  input  logic                                  arst_in,
  input  logic                                  start,
  input  logic [IO_DATA_WIDTH-1:0]              px_in,
  input  logic                                  px_valid,
  output logic                                  px_ready,
  output logic [IO_DATA_WIDTH-1:0]              row_1,
  output logic [IO_DATA_WIDTH-1:0]              row_2,
  output logic [IO_DATA_WIDTH-1:0]              row_3,
  output logic                                  LE,
  output logic                                  shift,
  output logic                                  win_valid,
  output logic [$clog2(FEATURE_MAP_WIDTH)-1:0]  win_x,
  output logic [$clog2(FEATURE_MAP_HEIGHT)-1:0] win_y,
  output logic                                  frame_done
);

  localparam int DW  = IO_DATA_WIDTH;
  localparam int XW  = $clog2(FEATURE_MAP_WIDTH);
  localparam int YW  = $clog2(FEATURE_MAP_HEIGHT);
  localparam int DCW = $clog2(DRAIN_CYCLES);
  localparam logic [XW-1:0] X_LAST = XW'(FEATURE_MAP_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(FEATURE_MAP_HEIGHT - 1);

  feeder_state_t  state_q, state_d;
  logic           px_ready_q, px_ready_d;
  logic           frame_done_q, frame_done_d;
  logic [DCW-1:0] drain_q, drain_d;
  logic [XW-1:0]  x_q, x_d;
  logic [YW-1:0]  y_q, y_d;

  logic           s1_valid_q, s1_valid_d;
  logic [XW-1:0]  s1_x_q, s1_x_d;
  logic [YW-1:0]  s1_y_q, s1_y_d;
  logic [DW-1:0]  row_3_q, row_3_d;
  logic           s2_valid_q, s2_valid_d;
  logic [XW-1:0]  s2_x_q, s2_x_d;
  logic [YW-1:0]  s2_y_q, s2_y_d;
  logic           win_valid_q, win_valid_d;
  logic [XW-1:0]  win_x_q, win_x_d;
  logic [YW-1:0]  win_y_q, win_y_d;

  logic           xfer;
  logic [DW-1:0]  lb0_rdata, lb1_rdata;

  assign xfer = px_valid & px_ready_q;

  always_comb begin
    state_d      = state_q;
    px_ready_d   = px_ready_q;
    frame_done_d = 1'b0;
    drain_d      = drain_q;
    x_d          = x_q;
    y_d          = y_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = STREAM;
          px_ready_d = 1'b1;
          x_d        = '0;
          y_d        = '0;
        end
      end
      STREAM: begin
        if (xfer) begin
          if (x_q == X_LAST) begin
            x_d = '0;
            y_d = (y_q == Y_LAST) ? '0 : y_q + YW'(1);
          end else begin
            x_d = x_q + XW'(1);
          end
          if (x_q == X_LAST && y_q == Y_LAST) begin
            state_d    = DRAIN;
            px_ready_d = 1'b0;
            drain_d    = DCW'(DRAIN_CYCLES - 1);
          end
        end
      end
      DRAIN: begin
        if (drain_q == '0) begin
          state_d      = IDLE;
          frame_done_d = 1'b1;
        end else begin
          drain_d = drain_q - DCW'(1);
        end
      end
      default: begin
        state_d    = IDLE;
        px_ready_d = 1'b0;
      end
    endcase
  end

  // Coordinates ride alongside the pixel so each stage holds its last value in gaps.
  always_comb begin
    s1_valid_d  = xfer;
    s1_x_d      = xfer ? x_q : s1_x_q;
    s1_y_d      = xfer ? y_q : s1_y_q;
    row_3_d     = xfer ? px_in : row_3_q;
    s2_valid_d  = s1_valid_q;
    s2_x_d      = s1_valid_q ? s1_x_q : s2_x_q;
    s2_y_d      = s1_valid_q ? s1_y_q : s2_y_q;
    win_valid_d = s2_valid_q && (s2_x_q >= XW'(2)) && (s2_y_q >= YW'(2));
    win_x_d     = s2_valid_q ? s2_x_q : win_x_q;
    win_y_d     = s2_valid_q ? s2_y_q : win_y_q;
  end

  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      state_q      <= IDLE;
      px_ready_q   <= 1'b0;
      frame_done_q <= 1'b0;
      drain_q      <= '0;
      x_q          <= '0;
      y_q          <= '0;
      s1_valid_q   <= 1'b0;
      s1_x_q       <= '0;
      s1_y_q       <= '0;
      row_3_q      <= '0;
      s2_valid_q   <= 1'b0;
      s2_x_q       <= '0;
      s2_y_q       <= '0;
      win_valid_q  <= 1'b0;
      win_x_q      <= '0;
      win_y_q      <= '0;
    end else begin
      state_q      <= state_d;
      px_ready_q   <= px_ready_d;
      frame_done_q <= frame_done_d;
      drain_q      <= drain_d;
      x_q          <= x_d;
      y_q          <= y_d;
      s1_valid_q   <= s1_valid_d;
      s1_x_q       <= s1_x_d;
      s1_y_q       <= s1_y_d;
      row_3_q      <= row_3_d;
      s2_valid_q   <= s2_valid_d;
      s2_x_q       <= s2_x_d;
      s2_y_q       <= s2_y_d;
      win_valid_q  <= win_valid_d;
      win_x_q      <= win_x_d;
      win_y_q      <= win_y_d;
    end
  end

  // lb1 holds row y-1, lb0 holds row y-2; lb0 is refilled from what lb1 just read out.
  line_buffer_ram #(.DEPTH(FEATURE_MAP_WIDTH), .DW(DW), .AW(XW)) u_lb1 (
    .clk   (clk),
    .we    (s1_valid_q),
    .waddr (s1_x_q),
    .wdata (row_3_q),
    .re    (xfer),
    .raddr (x_q),
    .rdata (lb1_rdata)
  );

  line_buffer_ram #(.DEPTH(FEATURE_MAP_WIDTH), .DW(DW), .AW(XW)) u_lb0 (
    .clk   (clk),
    .we    (s1_valid_q),
    .waddr (s1_x_q),
    .wdata (lb1_rdata),
    .re    (xfer),
    .raddr (x_q),
    .rdata (lb0_rdata)
  );

  // Stale buffer contents from earlier frames are hidden by masking on the pixel row.
  assign row_3      = row_3_q;
  assign row_2      = (s1_y_q != '0) ? lb1_rdata : '0;
  assign row_1      = (s1_y_q >= YW'(2)) ? lb0_rdata : '0;
  assign px_ready   = px_ready_q;
  assign LE         = s1_valid_q;
  assign shift      = s2_valid_q;
  assign win_valid  = win_valid_q;
  assign win_x      = win_x_q;
  assign win_y      = win_y_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_css_row_feeder.sv
// Self-checking bench for css_row_feeder on a 4x4 frame with a behavioural window model.
module tb_css_row_feeder;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          arst_in, start, px_valid, px_ready;
  logic [DW-1:0] px_in, row_1, row_2, row_3;
  logic          LE, shift, win_valid, frame_done;
  logic [1:0]    win_x, win_y;

  always #5 clk = ~clk;

  css_row_feeder #(.IO_DATA_WIDTH(DW), .FEATURE_MAP_WIDTH(W), .FEATURE_MAP_HEIGHT(H)) dut (
    .clk(clk), .arst_in(arst_in), .start(start), .px_in(px_in), .px_valid(px_valid),
    .px_ready(px_ready), .row_1(row_1), .row_2(row_2), .row_3(row_3), .LE(LE),
    .shift(shift), .win_valid(win_valid), .win_x(win_x), .win_y(win_y),
    .frame_done(frame_done)
  );

  int n_err = 0;
  int n_chk = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: transfer history h[0]=last cycle .. h[3]=four cycles ago.
  typedef struct {bit v; int x; int y; int val; bit last;} tx_t;
  tx_t h[4];
  int  kk = 0;
  int  img[H][W];
  int  e_r1 = 0, e_r2 = 0, e_r3 = 0;
  int  css_col[3];
  int  css_win[3][3];
  int  rl[W*H][3];
  int  first_win[3][3];
  bit  got_first = 1'b0;
  int  le_cnt = 0, sh_cnt = 0, wv_cnt = 0, fd_cnt = 0;

  always @(negedge clk) begin
    tx_t cur;
    bit  ewv;
    if (arst_in) begin
      check("rst_px_ready", px_ready, 0);
      check("rst_LE", LE, 0);
      check("rst_shift", shift, 0);
      check("rst_win_valid", win_valid, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_rows", {row_1, row_2, row_3}, 0);
      check("rst_win_xy", {win_x, win_y}, 0);
      for (int i = 0; i < 4; i++) h[i].v = 1'b0;
      kk = 0; e_r1 = 0; e_r2 = 0; e_r3 = 0;
    end else begin
      if (h[0].v) begin
        e_r3 = h[0].val;
        e_r2 = (h[0].y >= 1) ? img[h[0].y-1][h[0].x] : 0;
        e_r1 = (h[0].y >= 2) ? img[h[0].y-2][h[0].x] : 0;
        rl[h[0].y*W + h[0].x][0] = row_1;
        rl[h[0].y*W + h[0].x][1] = row_2;
        rl[h[0].y*W + h[0].x][2] = row_3;
      end
      check("LE", LE, h[0].v);
      check("shift", shift, h[1].v);
      check("row_1", row_1, e_r1);
      check("row_2", row_2, e_r2);
      check("row_3", row_3, e_r3);
      ewv = h[2].v && h[2].x >= 2 && h[2].y >= 2;
      check("win_valid", win_valid, ewv);
      check("frame_done", frame_done, h[3].v && h[3].last);
      if (ewv) begin
        check("win_x", win_x, h[2].x);
        check("win_y", win_y, h[2].y);
        for (int c = 0; c < 3; c++)
          for (int r = 0; r < 3; r++)
            check("window", css_win[c][r], img[h[2].y-2+r][h[2].x-2+c]);
        if (!got_first) begin
          first_win = css_win;
          got_first = 1'b1;
        end
      end
      le_cnt += LE; sh_cnt += shift; wv_cnt += win_valid; fd_cnt += frame_done;
      // CSS window register: shift consumes the previously loaded column.
      if (shift) begin
        css_win[0] = css_win[1];
        css_win[1] = css_win[2];
        css_win[2] = css_col;
      end
      if (LE) begin
        css_col[0] = row_1; css_col[1] = row_2; css_col[2] = row_3;
      end
      cur.v = px_valid && px_ready;
      cur.x = 0; cur.y = 0; cur.val = 0; cur.last = 1'b0;
      if (cur.v) begin
        cur.x = kk % W; cur.y = kk / W; cur.val = px_in;
        cur.last = (kk == W*H - 1);
        img[cur.y][cur.x] = px_in;
        kk = cur.last ? 0 : kk + 1;
      end
      h[3] = h[2]; h[2] = h[1]; h[1] = h[0]; h[0] = cur;
    end
  end

  task automatic run_frame(input int off, input bit bubbles, input bit poke_start);
    int k = 0;
    int budget = 0;
    int le0 = le_cnt, sh0 = sh_cnt, wv0 = wv_cnt, fd0 = fd_cnt;
    got_first = 1'b0;
    @(posedge clk) #1;
    start = 1'b1; px_valid = 1'b0;
    @(posedge clk) #1;
    start = 1'b0;
    while (k < W*H && budget < 400) begin
      px_valid = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
      px_in = DW'(off + 16*(k / W) + k % W);
      if (poke_start) start = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (px_valid && px_ready) k++;
      @(posedge clk) #1;
      budget++;
    end
    check("frame_pixels", k, W*H);
    px_valid = 1'b0;
    start = poke_start;
    @(posedge clk) #1;
    start = 1'b0;
    for (int i = 0; i < 20 && fd_cnt == fd0; i++) @(negedge clk);
    check("frame_done_seen", fd_cnt - fd0, 1);
    check("le_count", le_cnt - le0, W*H);
    check("shift_count", sh_cnt - sh0, W*H);
    check("win_count", wv_cnt - wv0, 4);
    check("first_win_c2", {first_win[2][0], first_win[2][1], first_win[2][2]},
          {off + 'h02, off + 'h12, off + 'h22});
    check("first_win_c1", {first_win[1][0], first_win[1][1], first_win[1][2]},
          {off + 'h01, off + 'h11, off + 'h21});
    check("first_win_c0", {first_win[0][0], first_win[0][1], first_win[0][2]},
          {off + 'h00, off + 'h10, off + 'h20});
    check("pad_y0", {rl[1][0], rl[1][1], rl[1][2]}, {32'd0, 32'd0, off + 'h01});
    check("pad_y1", {rl[6][0], rl[6][1], rl[6][2]}, {32'd0, off + 'h02, off + 'h12});
    check("rows_y3", {rl[14][0], rl[14][1], rl[14][2]}, {off + 'h12, off + 'h22, off + 'h32});
  endtask

  initial begin
    int k;
    arst_in = 1'b0; start = 1'b0; px_valid = 1'b0; px_in = '0;
    #1 arst_in = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk) #1 arst_in = 1'b0;

    run_frame(0, 1'b0, 1'b0);
    run_frame('h100, 1'b1, 1'b1);

    px_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("idle_no_ready", px_ready, 0);
    end
    px_valid = 1'b0;

    @(posedge clk) #1 start = 1'b1;
    @(posedge clk) #1 start = 1'b0;
    k = 0;
    for (int i = 0; i < 40 && k < 6; i++) begin
      px_valid = 1'b1;
      px_in = DW'('h300 + k);
      @(negedge clk);
      if (px_valid && px_ready) k++;
      @(posedge clk) #1;
    end
    check("mid_pixels", k, 6);
    arst_in = 1'b1;
    @(negedge clk);
    check("mid_rst_LE", LE, 0);
    check("mid_rst_ready", px_ready, 0);
    @(posedge clk) #1 arst_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst_ready", px_ready, 0);
    end
    px_valid = 1'b0;

    run_frame('h200, 1'b0, 1'b0);
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
